pattern_blinker: RTL

Parametrised LED pattern sequencer for board-level status signalling, for example SOS or heartbeat codes.
- A pattern word, its length, a repeat count and an inter-pass gap are loaded through a valid/ready handshake.
- The loaded bits are shifted onto the LED at a prescaled step rate.
- Sits between board-level control logic and the LED pin; replaces free-running hard-wired pattern blinkers.

---
 rtl/blink_pkg.sv | 17 +
 rtl/blink_prescaler.sv | 27 ++
 rtl/pattern_blinker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared types for the pattern blinker: FSM state encoding
// and the effective pattern-length rule.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A zero or oversized length means "use the whole word".
  function automatic int eff_len(input int len, input int pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Step prescaler: counts while enabled, ticks on all-ones and wraps.
// Held at zero whenever it is disabled or cleared.
module blink_prescaler #(
  parameter int DIV_W = 21
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clear || !en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (&r_cnt);

endmodule

// File: rtl/pattern_blinker.sv
// LED pattern sequencer with repeat count and inter-pass gap.
// Optional PWM dimming of on-bits: define PATTERN_BLINKER_DIM_EN.
module pattern_blinker
  import blink_pkg::*;
#(
  parameter int PAT_W      = 32,
  parameter int DIV_W      = 21,
  parameter int REP_W      = 8,
  parameter int GAP_W      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       pat_valid,
  output logic                       pat_ready,
  input  logic [PAT_W-1:0]           pat_bits,
  input  logic [$clog2(PAT_W+1)-1:0] pat_len,
  input  logic [REP_W-1:0]           pat_reps,
  input  logic [GAP_W-1:0]           pat_gap,
  input  logic                       abort,
`ifdef PATTERN_BLINKER_DIM_EN
  input  logic [7:0]                 dim_duty,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       LED
);

  localparam int   LW = $clog2(PAT_W + 1);
  localparam int   IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);

  state_t           r_state;
  logic [PAT_W-1:0] r_bits;
  logic [LW-1:0]    r_len;
  logic [REP_W-1:0] r_reps;
  logic [GAP_W-1:0] r_gap;
  logic [IW-1:0]    r_idx;
  logic [REP_W-1:0] r_pass;
  logic [GAP_W-1:0] r_gcnt;
  logic             r_led;
  logic             r_done;

  logic          w_tick;
  logic          w_idle;
  logic          w_accept;
  logic          w_last;
  logic          w_final;
  logic          w_on;
  logic [IW-1:0] w_nidx;
  logic [LW-1:0] w_len_eff;

`ifdef PATTERN_BLINKER_DIM_EN
  logic [7:0] r_pwm;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pwm <= '0;
    else     r_pwm <= r_pwm + 8'd1;
  end

  assign w_on = (r_pwm < dim_duty);
`else
  assign w_on = 1'b1;
`endif

  assign w_idle    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign pat_ready = !RST && w_idle && !abort;
  assign w_accept  = pat_valid && pat_ready;
  assign w_len_eff = LW'(eff_len(int'(pat_len), PAT_W));
  assign w_nidx    = r_idx + IW'(1);
  assign w_last    = ((LW'(r_idx) + LW'(1)) == r_len);
  assign w_final   = (r_reps != '0) && ((r_pass + REP_W'(1)) == r_reps);

  assign busy = (r_state == ST_RUN) || (r_state == ST_GAP);
  assign done = r_done;
  assign LED  = r_led;

  blink_prescaler #(.DIV_W(DIV_W)) u_presc (
    .CLK   (CLK),
    .RST   (RST),
    .clear (w_accept || abort),
    .en    (busy),
    .tick  (w_tick)
  );

  // LED is loaded with the bit of the *next* index on a step edge
  // so every bit is held for exactly one full step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_bits  <= '0;
      r_len   <= '0;
      r_reps  <= '0;
      r_gap   <= '0;
      r_idx   <= '0;
      r_pass  <= '0;
      r_gcnt  <= '0;
      r_led   <= AL;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_led   <= AL;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            r_led <= AL;
            if (w_accept) begin
              r_bits  <= pat_bits;
              r_len   <= w_len_eff;
              r_reps  <= pat_reps;
              r_gap   <= pat_gap;
              r_idx   <= '0;
              r_pass  <= '0;
              r_gcnt  <= '0;
              r_state <= ST_RUN;
              r_led   <= (pat_bits[0] & w_on) ^ AL;
            end
          end
          ST_RUN: begin
            r_led <= (r_bits[r_idx] & w_on) ^ AL;
            if (w_tick) begin
              if (!w_last) begin
                r_idx <= w_nidx;
                r_led <= (r_bits[w_nidx] & w_on) ^ AL;
              end else begin
                if (r_pass != '1) r_pass <= r_pass + REP_W'(1);
                if (w_final) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_led   <= AL;
                end else if (r_gap != '0) begin
                  r_state <= ST_GAP;
                  r_gcnt  <= '0;
                  r_led   <= AL;
                end else begin
                  r_idx <= '0;
                  r_led <= (r_bits[0] & w_on) ^ AL;
                end
              end
            end
          end
          ST_GAP: begin
            r_led <= AL;
            if (w_tick) begin
              if (r_gcnt == (r_gap - GAP_W'(1))) begin
                r_state <= ST_RUN;
                r_idx   <= '0;
                r_led   <= (r_bits[0] & w_on) ^ AL;
              end else begin
                r_gcnt <= r_gcnt + GAP_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule
